onehot_decoder_hold: RTL and testbench

//  Converts a stream of encoded request tokens {code, en} back into one-hot select lines.

---
 rtl/onehot_decoder_hold.sv | 167 ++++++++++++++++
 tb/tb_onehot_decoder_hold.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/onehot_decoder_hold.sv
// -----------------------------------------------------------------------------
// onehot_decoder_hold
//
// Converts a stream of encoded request tokens {code, en} back into one-hot
// select lines. This block sits after a priority encoder and takes the
// {out, valid} pair that the encoder produces.
//
// Each accepted token drives its one-hot line for HOLD_CYCLES cycles and then
// releases it. Upstream flow control is valid/ready. Downstream can end a hold
// early with out_ack. When a new token is waiting on the last cycle of a hold,
// it loads straight away, so there is no idle gap between tokens.
//
// Parameters
//   IN_W        width of the encoded index
//   OUT_W       one-hot width (must equal 2**IN_W)
//   HOLD_CYCLES cycles each token is driven (1 .. 2**CNT_W)
//   CNT_W       hold-counter width
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   in_valid    upstream token present
//   in_ready    token can be accepted this cycle (combinational, 0 during rst)
//   in_code     encoded index
//   in_en       encoder valid; 0 means an explicit "no request" token
//   out_ack     downstream ack; makes the current DRIVE cycle the last one
//   out_valid   a token is being driven
//   out_onehot  decoded select lines (all zero or exactly one-hot)
//   done        single-cycle pulse in the cycle after a hold ends
// -----------------------------------------------------------------------------
module onehot_decoder_hold #(
  parameter int IN_W        = 2,
  parameter int OUT_W       = 4,
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_code,
  input  logic             in_en,
  input  logic             out_ack,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_onehot,
  output logic             done
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_t;

  // The counter loads HOLD_CYCLES-1 and counts down to 0. The cycle where it
  // reaches 0 is the final cycle of the hold.
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  state_t             state_reg,      state_next;
  logic [CNT_W-1:0]   cnt_reg,        cnt_next;
  logic [IN_W-1:0]    code_reg,       code_next;
  logic               en_reg,         en_next;
  logic               out_valid_reg,  out_valid_next;
  logic [OUT_W-1:0]   out_onehot_reg, out_onehot_next;
  logic               done_reg,       done_next;

  logic               last;
  logic               accept;
  logic [OUT_W-1:0]   in_dec;
  logic [OUT_W-1:0]   hold_dec;

  // Two decoders, one per source of a code:
  //   in_dec   decodes the incoming token and is used when a token loads.
  //   hold_dec decodes the latched token and is used while a hold continues.
  // Each bit checks for exactly one code value, and both decoders are gated
  // by their enable. This means the result can never have more than one bit
  // set.
  generate
    for (genvar gi = 0; gi < OUT_W; gi++) begin : g_dec
      assign in_dec[gi]   = in_en  && (in_code  == IN_W'(gi));
      assign hold_dec[gi] = en_reg && (code_reg == IN_W'(gi));
    end
  endgenerate

  // The current DRIVE cycle is the last one when the counter has run out or
  // downstream has acked. out_ack has no effect in IDLE.
  assign last     = (state_reg == DRIVE) && ((cnt_reg == '0) || out_ack);
  assign in_ready = !rst && ((state_reg == IDLE) || last);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    code_next       = code_reg;
    en_next         = en_reg;
    out_valid_next  = out_valid_reg;
    out_onehot_next = out_onehot_reg;
    done_next       = last;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next      = DRIVE;
          cnt_next        = HOLD_LOAD;
          code_next       = in_code;
          en_next         = in_en;
          out_valid_next  = 1'b1;
          out_onehot_next = in_dec;
        end
      end

      DRIVE: begin
        if (!last) begin
          // Mid-hold: count down. The decode of the latched token is the
          // same value already on the outputs.
          cnt_next        = cnt_reg - CNT_W'(1);
          out_onehot_next = hold_dec;
        end else if (accept) begin
          // A waiting token replaces the finishing one back to back.
          // out_valid stays high.
          cnt_next        = HOLD_LOAD;
          code_next       = in_code;
          en_next         = in_en;
          out_valid_next  = 1'b1;
          out_onehot_next = in_dec;
        end else begin
          state_next      = IDLE;
          out_valid_next  = 1'b0;
          out_onehot_next = '0;
        end
      end

      default: begin
        state_next      = IDLE;
        out_valid_next  = 1'b0;
        out_onehot_next = '0;
      end
    endcase
  end

  // Reset takes priority over everything else, including an accept in the
  // same cycle. The done register is cleared as well, so a hold that reset
  // cuts short does not produce a completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      code_reg       <= '0;
      en_reg         <= 1'b0;
      out_valid_reg  <= 1'b0;
      out_onehot_reg <= '0;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      code_reg       <= code_next;
      en_reg         <= en_next;
      out_valid_reg  <= out_valid_next;
      out_onehot_reg <= out_onehot_next;
      done_reg       <= done_next;
    end
  end

  assign out_valid  = out_valid_reg;
  assign out_onehot = out_onehot_reg;
  assign done       = done_reg;

endmodule

// File: tb/tb_onehot_decoder_hold.sv
// -----------------------------------------------------------------------------
// tb_onehot_decoder_hold
//
// Directed bench for onehot_decoder_hold. It contains two instances:
//   dut  uses HOLD_CYCLES=4 and covers the main scenarios.
//   dut1 uses HOLD_CYCLES=1 and checks one token per cycle throughput.
// Inputs are driven 1 ns after the rising edge. Outputs are checked at the
// same point, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_onehot_decoder_hold;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_en, out_ack;
  logic [1:0] in_code;
  logic       in_ready, out_valid, done;
  logic [3:0] out_onehot;

  logic       v1, en1, ack1;
  logic [1:0] code1;
  logic       ready1, valid1, done1;
  logic [3:0] onehot1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  onehot_decoder_hold #(.IN_W(2), .OUT_W(4), .HOLD_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .in_en(in_en), .out_ack(out_ack),
    .out_valid(out_valid), .out_onehot(out_onehot), .done(done)
  );

  onehot_decoder_hold #(.IN_W(2), .OUT_W(4), .HOLD_CYCLES(1), .CNT_W(3)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(ready1),
    .in_code(code1), .in_en(en1), .out_ack(ack1),
    .out_valid(valid1), .out_onehot(onehot1), .done(done1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected one-hot patterns for codes 0..3.
  logic [3:0] oh_tab [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

  initial begin
    logic [1:0] seq_code [3];
    logic [3:0] seq_exp  [3];
    seq_code = '{2'd3, 2'd1, 2'd0};
    seq_exp  = '{4'b1000, 4'b0010, 4'b0001};

    rst = 1'b1; in_valid = 1'b0; in_code = '0; in_en = 1'b0; out_ack = 1'b0;
    v1 = 1'b0; code1 = '0; en1 = 1'b0; ack1 = 1'b0;

    // 1. Reset
    tick(); tick();
    chk("rst_valid",  out_valid,  0);
    chk("rst_onehot", out_onehot, 0);
    chk("rst_done",   done,       0);
    chk("rst_ready",  in_ready,   0);
    chk("rst_valid1", valid1,     0);
    rst = 1'b0; #1;
    chk("post_rst_ready", in_ready, 1);
    $display("txn reset: done");

    // 2. Single token, code 3, no ack. The inputs change straight after the
    // accept; the outputs must keep the latched value.
    in_valid = 1'b1; in_code = 2'd3; in_en = 1'b1;
    tick();
    in_valid = 1'b0; in_code = 2'd0; in_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t2_onehot_c%0d", k), out_onehot, 4'b1000);
      chk($sformatf("t2_valid_c%0d", k),  out_valid,  1);
      chk($sformatf("t2_ready_c%0d", k),  in_ready,   (k == 3) ? 1 : 0);
      chk($sformatf("t2_done_c%0d", k),   done,       0);
      tick();
    end
    chk("t2_idle_valid",  out_valid,  0);
    chk("t2_idle_onehot", out_onehot, 0);
    chk("t2_done_pulse",  done,       1);
    tick();
    chk("t2_done_clear", done, 0);
    $display("txn single code=3: onehot=1000 x4");

    // 3. Back-to-back tokens with in_valid held high
    in_valid = 1'b1; in_en = 1'b1; in_code = seq_code[0];
    tick();
    for (int t = 0; t < 3; t++) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("t3_onehot_t%0d_c%0d", t, k), out_onehot, seq_exp[t]);
        chk($sformatf("t3_valid_t%0d_c%0d", t, k),  out_valid,  1);
        chk($sformatf("t3_ready_t%0d_c%0d", t, k),  in_ready,   (k == 3) ? 1 : 0);
        chk($sformatf("t3_done_t%0d_c%0d", t, k),   done,       (k == 0 && t > 0) ? 1 : 0);
        if (k == 3) begin
          if (t < 2) in_code = seq_code[t+1];
          else       in_valid = 1'b0;
        end
        tick();
      end
      $display("txn b2b token %0d: onehot=%b x4", t, seq_exp[t]);
    end
    chk("t3_idle_valid", out_valid, 0);
    chk("t3_done_pulse", done,      1);
    tick();

    // 4. Code 2, acked in the 2nd DRIVE cycle
    in_valid = 1'b1; in_code = 2'd2; in_en = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t4_onehot_c0", out_onehot, 4'b0100);
    chk("t4_ready_c0",  in_ready,   0);
    tick();
    out_ack = 1'b1; #1;
    chk("t4_onehot_c1", out_onehot, 4'b0100);
    chk("t4_ready_ack", in_ready,   1);
    tick();
    out_ack = 1'b0;
    chk("t4_idle_valid",  out_valid,  0);
    chk("t4_idle_onehot", out_onehot, 0);
    chk("t4_done_pulse",  done,       1);
    tick();
    chk("t4_done_clear", done, 0);
    $display("txn ack code=2: onehot=0100 x2");

    // out_ack while IDLE must not do anything
    out_ack = 1'b1;
    tick();
    chk("idle_ack_valid", out_valid, 0);
    chk("idle_ack_done",  done,      0);
    chk("idle_ack_ready", in_ready,  1);
    out_ack = 1'b0;
    $display("txn ack in idle: ignored");

    // 5. en=0 token, which drives an explicit "none" for the full hold
    in_valid = 1'b1; in_code = 2'd1; in_en = 1'b0;
    tick();
    in_valid = 1'b0; in_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t5_valid_c%0d", k),  out_valid,  1);
      chk($sformatf("t5_onehot_c%0d", k), out_onehot, 0);
      tick();
    end
    chk("t5_idle_valid", out_valid, 0);
    chk("t5_done_pulse", done,      1);
    tick();
    $display("txn en=0: valid with onehot=0000 x4");

    // 6. Reset during the 3rd hold cycle, then reset against a simultaneous accept
    in_valid = 1'b1; in_code = 2'd1; in_en = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t6_onehot_c0", out_onehot, 4'b0010);
    tick(); tick();
    chk("t6_onehot_c2", out_onehot, 4'b0010);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_valid",  out_valid,  0);
    chk("t6_rst_onehot", out_onehot, 0);
    chk("t6_rst_done",   done,       0);
    tick();
    chk("t6_no_done", done, 0);
    rst = 1'b1; in_valid = 1'b1; in_code = 2'd0; #1;
    chk("t6_ready_in_rst", in_ready, 0);
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("t6_rst_dominates", out_valid, 0);
    $display("txn reset mid-hold: abandoned");

    // HOLD_CYCLES=1 instance: one token per cycle
    v1 = 1'b1; en1 = 1'b1; code1 = 2'd0;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("h1_onehot_%0d", i), onehot1, oh_tab[i]);
      chk($sformatf("h1_valid_%0d", i),  valid1,  1);
      chk($sformatf("h1_ready_%0d", i),  ready1,  1);
      chk($sformatf("h1_done_%0d", i),   done1,   (i > 0) ? 1 : 0);
      $display("txn hold1 token %0d: onehot=%b", i, onehot1);
      if (i < 3) code1 = 2'(i + 1);
      else       v1 = 1'b0;
      tick();
    end
    chk("h1_idle_valid", valid1, 0);
    chk("h1_done_last",  done1,  1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
